// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and fetch stage in front of a synchronous
// instruction ROM. Each word comes back one cycle after its read is issued.
// A 2-entry {pc, data} buffer then hands it to decode over valid/ready.
// Redirects flush everything in flight. Halt only stops new reads from issuing.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    MEMORY_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  rom_read_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_address,
    input  logic                  halt,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEMORY_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pending_pc;
    logic                  pending;

    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH-1:0] tail_pc;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [1:0]            occupancy;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            in_flight;

    // Issue only while the buffer plus the outstanding read still leaves room.
    // Gating with reset_n keeps the ROM strobe low for the whole reset.
    assign pop       = instr_valid & instr_ready;
    assign push      = pending;
    assign in_flight = {1'b0, occupancy} + {2'b00, pending} - {2'b00, pop};
    assign issue     = reset_n & ~halt & ~redirect_valid & (in_flight < 3'd2);

    assign rom_read_enable = issue;
    assign rom_address     = pc;

    assign instr_valid = (occupancy != 2'd0);
    assign instr_data  = head_data;
    assign instr_pc    = head_pc;

    // PC and in-flight read tracking; a redirect kills the outstanding return.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
        end else if (redirect_valid) begin
            pc      <= redirect_address;
            pending <= 1'b0;
        end else if (issue) begin
            pending    <= 1'b1;
            pending_pc <= pc;
            pc         <= (pc == LAST_PC) ? '0 : pc + ADDR_WIDTH'(1);
        end else begin
            pending <= 1'b0;
        end
    end

    // Two-entry return buffer; the head is always what decode currently sees.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= 2'd0;
            head_pc   <= '0;
            head_data <= '0;
            tail_pc   <= '0;
            tail_data <= '0;
        end else if (redirect_valid) begin
            occupancy <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        head_pc   <= pending_pc;
                        head_data <= rom_data;
                    end else begin
                        tail_pc   <= pending_pc;
                        tail_data <= rom_data;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_data <= tail_data;
                    occupancy <= occupancy - 2'd1;
                end
                2'b11: begin
                    if (occupancy == 2'd1) begin
                        head_pc   <= pending_pc;
                        head_data <= rom_data;
                    end else begin
                        head_pc   <= tail_pc;
                        head_data <= tail_data;
                        tail_pc   <= pending_pc;
                        tail_data <= rom_data;
                    end
                end
                default: begin
                    occupancy <= occupancy;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed test of the fetch stage against a
// synchronous ROM model. Expected words are queued when each scenario is set
// up. A monitor pops and compares them on every accepted handshake.
module tb_instruction_fetch;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rom_read_enable;
    logic [7:0] rom_address;
    logic [7:0] rom_data = 8'h00;
    logic       redirect_valid;
    logic [7:0] redirect_address;
    logic       halt;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       instr_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] expectQ[$];
    logic [7:0]  romMem[8];

    logic        prevStall = 1'b0;
    logic [7:0]  stallPc   = 8'h00;
    logic [7:0]  stallData = 8'h00;

    instruction_fetch #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .MEMORY_DEPTH(8),
        .RESET_PC(8'h00)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rom_read_enable(rom_read_enable),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .redirect_valid(redirect_valid),
        .redirect_address(redirect_address),
        .halt(halt),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Synchronous ROM: word i holds 0x10 + i and appears one cycle after the strobe.
    always @(posedge clock) begin
        if (rom_read_enable) rom_data <= romMem[rom_address % 8];
    end

    // Monitor: on each accepted handshake, compare against the next queued word.
    // It also checks that a stalled head holds steady into the next cycle.
    always @(negedge clock) begin
        logic [15:0] expWord;
        if (reset_n) begin
            if (prevStall) begin
                checks++;
                if (!instr_valid || instr_pc != stallPc || instr_data != stallData) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%0b pc=%0h data=%0h, expected valid=1 pc=%0h data=%0h",
                             instr_valid, instr_pc, instr_data, stallPc, stallData);
                end
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (expectQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output: got pc=%0h data=%0h, expected nothing", instr_pc, instr_data);
                end else begin
                    expWord = expectQ.pop_front();
                    if ({instr_pc, instr_data} != expWord) begin
                        errors++;
                        $display("[TB] FAIL stream_word: got pc=%0h data=%0h, expected pc=%0h data=%0h",
                                 instr_pc, instr_data, expWord[15:8], expWord[7:0]);
                    end
                end
            end
            prevStall = instr_valid && !instr_ready && !redirect_valid;
            stallPc   = instr_pc;
            stallData = instr_data;
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic applyStimulus(input logic ready, input logic haltIn,
                                 input logic redirectIn, input logic [7:0] target);
        instr_ready      = ready;
        halt             = haltIn;
        redirect_valid   = redirectIn;
        redirect_address = target;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int startPc, input int count);
        for (int i = 0; i < count; i++) begin
            logic [7:0] p;
            p = 8'((startPc + i) % 8);
            expectQ.push_back({p, 8'h10 + p});
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) romMem[i] = 8'(8'h10 + i);
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset values, with halt low and ready high so the strobe gating is exercised.
        stepCycle();
        stepCycle();
        checkOutput("reset_read_enable", int'(rom_read_enable), 0);
        checkOutput("reset_address", int'(rom_address), 0);
        checkOutput("reset_valid", int'(instr_valid), 0);
        checkOutput("reset_pc", int'(instr_pc), 0);
        checkOutput("reset_data", int'(instr_data), 0);

        // Release and stream: pcs 0..7, wrap, then across the backpressure window.
        pushExpected(0, 17);
        reset_n = 1'b1;
        #1;
        checkOutput("release_issue", int'(rom_read_enable), 1);
        checkOutput("release_address", int'(rom_address), 0);
        checkOutput("release_valid", int'(instr_valid), 0);
        stepCycle();
        #1;
        checkOutput("latency_c1_valid", int'(instr_valid), 0);
        checkOutput("latency_c1_address", int'(rom_address), 1);
        stepCycle();
        #1;
        checkOutput("latency_c2_valid", int'(instr_valid), 1);
        checkOutput("latency_c2_pc", int'(instr_pc), 0);
        checkOutput("latency_c2_data", int'(instr_data), 8'h10);

        // Backpressure for 5 cycles with head pc 2.
        runCycles(10);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("bp_issue_stop", int'(rom_read_enable), 0);
        runCycles(4);
        #1;
        checkOutput("bp_read_enable", int'(rom_read_enable), 0);
        checkOutput("bp_head_pc", int'(instr_pc), 2);
        checkOutput("bp_head_data", int'(instr_data), 8'h12);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        // Redirect to 5 while pc 1 is buffered and pc 2 is in flight.
        runCycles(7);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h05);
        #1;
        checkOutput("redir_head_pc", int'(instr_pc), 1);
        checkOutput("redir_no_issue", int'(rom_read_enable), 0);
        pushExpected(5, 10);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("redir_r1_valid", int'(instr_valid), 0);
        checkOutput("redir_r1_issue", int'(rom_read_enable), 1);
        checkOutput("redir_r1_address", int'(rom_address), 5);
        stepCycle();
        #1;
        checkOutput("redir_r2_valid", int'(instr_valid), 0);
        stepCycle();
        #1;
        checkOutput("redir_r3_valid", int'(instr_valid), 1);
        checkOutput("redir_r3_pc", int'(instr_pc), 5);
        checkOutput("redir_r3_data", int'(instr_data), 8'h15);

        // Halt for 4 cycles; the buffer drains, then fetch resumes at pc 2.
        runCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("halt_no_issue", int'(rom_read_enable), 0);
        runCycles(2);
        #1;
        checkOutput("halt_drained", int'(instr_valid), 0);
        checkOutput("halt_no_issue_late", int'(rom_read_enable), 0);
        stepCycle();
        #1;
        checkOutput("halt_still_empty", int'(instr_valid), 0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("unhalt_issue", int'(rom_read_enable), 1);
        checkOutput("unhalt_address", int'(rom_address), 2);
        runCycles(2);
        #1;
        checkOutput("unhalt_pc", int'(instr_pc), 2);
        checkOutput("unhalt_data", int'(instr_data), 8'h12);

        // Redirect to 3 while halting; the head (pc 6) is still accepted.
        runCycles(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h03);
        pushExpected(3, 5);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("rh_no_issue", int'(rom_read_enable), 0);
        checkOutput("rh_address", int'(rom_address), 3);
        checkOutput("rh_valid", int'(instr_valid), 0);
        stepCycle();
        #1;
        checkOutput("rh_hold_address", int'(rom_address), 3);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("rh_release_issue", int'(rom_read_enable), 1);
        checkOutput("rh_release_address", int'(rom_address), 3);
        runCycles(2);
        #1;
        checkOutput("rh_first_pc", int'(instr_pc), 3);
        checkOutput("rh_first_data", int'(instr_data), 8'h13);

        // Async reset between edges, then restart from RESET_PC.
        runCycles(5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_valid", int'(instr_valid), 0);
        checkOutput("async_read_enable", int'(rom_read_enable), 0);
        checkOutput("async_address", int'(rom_address), 0);
        pushExpected(0, 5);
        stepCycle();
        reset_n = 1'b1;
        #1;
        checkOutput("restart_issue", int'(rom_read_enable), 1);
        checkOutput("restart_address", int'(rom_address), 0);
        runCycles(2);
        #1;
        checkOutput("restart_pc", int'(instr_pc), 0);
        checkOutput("restart_data", int'(instr_data), 8'h10);
        runCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        runCycles(3);

        checkOutput("queue_empty", expectQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
